// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Purpose:
//    Round-robin arbiter that shares the single write port of an 8-entry,
//    32-bit fifo between N producers. Each write is run as a short sequence:
//    full check, a one-cycle write strobe, then sampling of the fifo's
//    accept/reject response. A rejected (or unanswered) write is retried by
//    the same owner up to MAX_RETRY attempts. After that the request is
//    dropped. Every completion or drop is reported back to the requester as
//    a one-cycle pulse.
//
// Ports:
//    clk          system clock, rising edge
//    reset_n      asynchronous active-low reset
//    req          one request bit per producer. It is held high with its data
//                 stable until done or drop.
//    din_bus      producer data, slice i = din_bus[i*DW +: DW]
//    gnt          one-hot owner of the current transaction
//    done         one-cycle pulse, the owner's write was accepted
//    drop         one-cycle pulse, the owner's request was abandoned
//    fifo_wr_en   write strobe to the fifo, one cycle per attempt
//    fifo_din     write data to the fifo
//    fifo_full    fifo full flag
//    fifo_wr_ack  fifo accepted the write (cycle after wr_en is sampled)
//    fifo_wr_err  fifo rejected the write (same timing as wr_ack)
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int N         = 4,
   parameter int DW        = 32,
   parameter int MAX_RETRY = 3
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [N-1:0]    req,
   input  logic [N*DW-1:0] din_bus,
   output logic [N-1:0]    gnt,
   output logic [N-1:0]    done,
   output logic [N-1:0]    drop,
   output logic            fifo_wr_en,
   output logic [DW-1:0]   fifo_din,
   input  logic            fifo_full,
   input  logic            fifo_wr_ack,
   input  logic            fifo_wr_err
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int RW = $clog2(MAX_RETRY + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   rrPtr_q, rrPtr_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [RW-1:0]   retryCnt_q, retryCnt_d;
   logic            lock_q, lock_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [N-1:0]    done_q, done_d;
   logic [N-1:0]    drop_q, drop_d;
   logic            wrEn_q, wrEn_d;
   logic [DW-1:0]   din_q, din_d;

   logic            rrFound;
   logic [PW-1:0]   rrWinner;
   logic            ownerReq;
   logic            keepOwner;
   logic            winValid;
   logic [PW-1:0]   winner;
   logic [PW-1:0]   nextOwner;
   logic            rejected;
   logic            retryExhausted;

   // Round-robin search: first set request starting at rrPtr and wrapping
   // from N-1 back to 0. The index is kept modulo N, so non-power-of-two N
   // never looks past the last requester.
   always_comb begin
      int idx;
      logic [PW-1:0] idxP;
      rrFound  = 1'b0;
      rrWinner = '0;
      idx      = 0;
      idxP     = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(rrPtr_q) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         idxP = PW'(idx);
         if (!rrFound && req[idxP]) begin
            rrFound  = 1'b1;
            rrWinner = idxP;
         end
      end
   end

   // Winner selection. A locked owner that still requests is retried ahead of
   // everybody else. A locked owner that let go of its request releases the
   // lock, and the normal round-robin result is used in the same cycle.
   // A full fifo blocks any new attempt, including a retry.
   always_comb begin
      ownerReq  = req[owner_q];
      keepOwner = lock_q && ownerReq;
      winValid  = !fifo_full && (keepOwner || rrFound);
      winner    = keepOwner ? owner_q : rrWinner;
      nextOwner = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);
   end

   // Response decode for WAIT. An acknowledge always wins. An explicit error
   // and a missing response both take the retry path.
   always_comb begin
      rejected       = fifo_wr_err || !fifo_wr_ack;
      retryExhausted = (int'(retryCnt_q) + 1) >= MAX_RETRY;
   end

   // State register plus the registered outputs and bookkeeping. Reset
   // abandons any attempt in flight without reporting it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         rrPtr_q    <= '0;
         owner_q    <= '0;
         retryCnt_q <= '0;
         lock_q     <= 1'b0;
         gnt_q      <= '0;
         done_q     <= '0;
         drop_q     <= '0;
         wrEn_q     <= 1'b0;
         din_q      <= '0;
      end else begin
         state_q    <= state_d;
         rrPtr_q    <= rrPtr_d;
         owner_q    <= owner_d;
         retryCnt_q <= retryCnt_d;
         lock_q     <= lock_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         drop_q     <= drop_d;
         wrEn_q     <= wrEn_d;
         din_q      <= din_d;
      end
   end

   // Next-state logic. Every attempt runs IDLE -> WRITE -> WAIT -> IDLE, so
   // at most one attempt is issued every three cycles.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (winValid) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            state_d = WAIT;
         end
         WAIT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output and bookkeeping logic. done/drop/wr_en are pulses and default to
   // zero. Grant, data, owner and the retry state hold unless a transition
   // below changes them.
   always_comb begin
      rrPtr_d    = rrPtr_q;
      owner_d    = owner_q;
      retryCnt_d = retryCnt_q;
      lock_d     = lock_q;
      gnt_d      = gnt_q;
      din_d      = din_q;
      done_d     = '0;
      drop_d     = '0;
      wrEn_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            // The owner gave up a pending retry, so its lock and count are
            // cleared before the new winner (if any) is taken.
            if (!fifo_full && lock_q && !ownerReq) begin
               lock_d     = 1'b0;
               retryCnt_d = '0;
               gnt_d      = '0;
            end
            if (winValid) begin
               owner_d        = winner;
               gnt_d          = '0;
               gnt_d[winner]  = 1'b1;
               din_d          = din_bus[int'(winner)*DW +: DW];
               wrEn_d         = 1'b1;
            end
         end
         WRITE: begin
            // The fifo samples the strobe at this edge. Data and grant stay
            // put until the response is seen.
            wrEn_d = 1'b0;
         end
         WAIT: begin
            if (fifo_wr_ack) begin
               done_d[owner_q] = 1'b1;
               gnt_d           = '0;
               retryCnt_d      = '0;
               lock_d          = 1'b0;
               rrPtr_d         = nextOwner;
            end else if (rejected) begin
               if (retryExhausted) begin
                  drop_d[owner_q] = 1'b1;
                  gnt_d           = '0;
                  retryCnt_d      = '0;
                  lock_d          = 1'b0;
                  rrPtr_d         = nextOwner;
               end else begin
                  retryCnt_d = retryCnt_q + RW'(1);
                  lock_d     = 1'b1;
               end
            end
         end
         default: begin
            gnt_d = '0;
         end
      endcase
   end

   assign gnt        = gnt_q;
   assign done       = done_q;
   assign drop       = drop_q;
   assign fifo_wr_en = wrEn_q;
   assign fifo_din   = din_q;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the 8-entry, 32-bit fifo between N producers.
- Sequences each write: full check, one-cycle wr_en pulse, then sampling of the fifo's wr_ack/wr_err.
- Retries a rejected write and reports per-requester completion or drop.
- Sits directly in front of fifo: fifo_wr_en/fifo_din connect to fifo wr_en/din; fifo full/wr_ack/wr_err feed back.

Parameters:
N, 4, number of requesters (2..8)
DW, 32, data width, matches fifo din
MAX_RETRY, 3, rejected attempts allowed before a request is dropped (1..15)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req  in  N  request per producer; held high with its data stable until done or drop
din_bus  in  N*DW  producer data, slice i = din_bus[i*DW +: DW]
gnt  out  N  one-hot, owner of the current transaction
done  out  N  one-cycle pulse, write of requester i accepted (wr_ack seen)
drop  out  N  one-cycle pulse, request i abandoned after MAX_RETRY wr_err
fifo_wr_en  out  1  write strobe to fifo, exactly one cycle per attempt
fifo_din  out  DW  write data to fifo
fifo_full  in  1  fifo full flag
fifo_wr_ack  in  1  fifo write accepted, valid the cycle after wr_en is sampled
fifo_wr_err  in  1  fifo write rejected, same timing as wr_ack

Behaviour:
- Reset (async, reset_n=0):
  - gnt=0, done=0, drop=0, fifo_wr_en=0, fifo_din=0.
  - state=IDLE, rr_ptr=0, retry_cnt=0, lock=0.
- All outputs are registered.
- FSM states: IDLE, WRITE, WAIT.
- IDLE:
  - No action if fifo_full=1 or no eligible req.
  - If lock=1 and req[owner]=1: owner keeps the grant (retry).
  - If lock=1 and req[owner]=0: lock is cleared and normal arbitration runs the same cycle.
  - Otherwise the winner is the first set req bit searching from rr_ptr upward, wrapping N-1 to 0.
  - On a win at the edge: gnt=onehot(winner), fifo_din=din slice, fifo_wr_en=1, state goes to WRITE.
- WRITE:
  - fifo samples wr_en at this edge.
  - Arbiter drops fifo_wr_en to 0 and goes to WAIT. fifo_din and gnt hold.
- WAIT, evaluated on the sampled fifo_wr_ack/fifo_wr_err:
  - ack=1: done[owner]=1 for one cycle, gnt=0, retry_cnt=0, lock=0, rr_ptr=(owner+1) mod N, state goes to IDLE.
  - err=1, or neither set (missing response is treated as err): retry_cnt+1.
    - If the new count is below MAX_RETRY: lock=1, gnt holds, state goes to IDLE.
    - If the new count equals MAX_RETRY: drop[owner]=1 for one cycle, gnt=0, retry_cnt=0, lock=0, rr_ptr=(owner+1) mod N, state goes to IDLE.
  - ack and err both set: ack wins.
- Throughput: one attempt per 3 cycles. Minimum latency from req high to done is 3 edges.
- req[owner] falling during WRITE/WAIT does not abort the attempt; done or drop still pulses. Falling req only cancels a pending retry.
- done and drop are never both set. At most one bit of gnt, done or drop is set at a time.
- retry_cnt width is clog2(MAX_RETRY+1). rr_ptr width is clog2(N), wrapping modulo N.
- reset_n asserted mid-transaction aborts immediately to the reset values. A write the fifo already sampled is not reported.

Test Plan:
1. Reset then single writer: req=4'b0001, din0=32'h11, fifo empty -> fifo_wr_en one cycle with fifo_din=32'h11, wr_ack returned, done[0] 3 edges after req, gnt back to 0.
2. Round robin: req=4'b1111, din_i=32'h10+i, fifo always acks -> grant order 0,1,2,3, fifo receives 10,11,12,13. Requesters drop req after done, and no fifo_wr_en is issued after the four writes.
3. Full stall: push 8 writes from requester 2 (32'h21..28) until fifo_full=1 -> no fifo_wr_en while full. After one fifo read the 9th write (32'h29) issues, done[2] pulses, data_count returns to 8.
4. Retry then drop: fifo model forces wr_err for req[1]=1 with din1=32'hAA -> 3 attempts, gnt[1] held throughout, drop[1] pulse, done[1] never set, rr_ptr=2.
5. Retry recovery: wr_err on the first attempt of requester 3, wr_ack on the second -> exactly 2 fifo_wr_en pulses, done[3] pulse, retry_cnt=0, requester 0 (also requesting) served next.
6. Mid-op reset: reset_n=0 during WAIT -> gnt, fifo_wr_en, done and drop go to 0 immediately. After release, req=4'b0100 is granted first with rr_ptr=0 search order.
